uart_alu_interface: RTL and testbench

- Control stage between the UART RX/TX cores and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, opcode) and drives them as registered ALU inputs.
- Samples the ALU result and overflow, then sends two bytes back through UART TX: the result byte, then a status byte.
- Includes an inter-byte timeout that resynchronises the frame if the host stalls mid-frame.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/timeout_counter.sv | 35 +++
 rtl/uart_alu_interface.sv | 180 ++++++++++++++++++
 tb/tb_uart_alu_interface.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, interface FSM states and
// status-byte bit positions. Used by the ALU, its UART interface and benches.
package alu_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

    // Bit positions inside the status reply byte
    localparam int unsigned STAT_OVF = 0;
    localparam int unsigned STAT_INV = 1;

    typedef enum logic [2:0] {
        ST_WAIT_A      = 3'd0,
        ST_WAIT_B      = 3'd1,
        ST_WAIT_OP     = 3'd2,
        ST_EXEC        = 3'd3,
        ST_WAIT_TX_RES = 3'd4,
        ST_WAIT_TX_ST  = 3'd5
    } state_t;

    // True when the opcode is one the ALU implements
    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        logic valid;
        valid = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: valid = 1'b1;
            default:                        valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Inter-byte idle timer.
// Ports: i_clk, i_rst_n (async active-low), i_clear (restart count),
//        i_en (count while high, held at zero while low),
//        o_expired (count has reached TIMEOUT_CYC-1 while enabled).
module timeout_counter
#(
    parameter int unsigned TIMEOUT_CYC = 1048576
)
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Saturate at the last value so the count never wraps before the FSM leaves
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clear || !i_en) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_expired = i_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_alu_interface.sv
// Control stage between UART RX/TX and a combinational ALU.
// Receives operand A, operand B and opcode bytes, presents them as
// registered ALU inputs, then returns the result byte and a status byte
// ({0.., invalid_op, overflow}) over UART TX. A stalled frame is dropped
// after TIMEOUT_CYC idle cycles between bytes.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_rx_data, i_rx_done      received byte and its one-cycle strobe
//   i_tx_done                 TX finished the current byte
//   i_alu_result/overflow     combinational ALU outputs
//   o_alu_dataA/B, o_alu_op   registered ALU inputs
//   o_tx_data, o_tx_start     byte to transmit and its one-cycle request
//   o_busy                    frame is executing or being transmitted
module uart_alu_interface
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned NB_OP       = 6,
    parameter int unsigned TIMEOUT_CYC = 1048576
)
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_overflow,
    output logic [NB_DATA-1:0] o_alu_dataA,
    output logic [NB_DATA-1:0] o_alu_dataB,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    state_t state_q;
    state_t state_d;

    logic               load_a_c;
    logic               load_b_c;
    logic               load_op_c;
    logic               load_res_c;
    logic               load_st_c;
    logic               cnt_en_c;
    logic               cnt_clr_c;
    logic               expired_c;
    logic               invalid_op_c;
    logic               busy_d_c;
    logic [NB_DATA-1:0] status_d_c;
    logic [NB_DATA-1:0] status_q;

    timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (cnt_clr_c),
        .i_en      (cnt_en_c),
        .o_expired (expired_c)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; an rx byte arriving on the expiry cycle takes priority
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (i_rx_done)      state_d = ST_WAIT_OP;
                else if (expired_c) state_d = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (i_rx_done)      state_d = ST_EXEC;
                else if (expired_c) state_d = ST_WAIT_A;
            end
            ST_EXEC: begin
                state_d = ST_WAIT_TX_RES;
            end
            ST_WAIT_TX_RES: begin
                if (i_tx_done) state_d = ST_WAIT_TX_ST;
            end
            ST_WAIT_TX_ST: begin
                if (i_tx_done) state_d = ST_WAIT_A;
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
    end

    // Load strobes and timer control; rx bytes in busy states are simply dropped
    always_comb begin
        load_a_c   = 1'b0;
        load_b_c   = 1'b0;
        load_op_c  = 1'b0;
        load_res_c = 1'b0;
        load_st_c  = 1'b0;
        cnt_en_c   = 1'b0;
        cnt_clr_c  = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                load_a_c = i_rx_done;
            end
            ST_WAIT_B: begin
                load_b_c  = i_rx_done;
                cnt_en_c  = 1'b1;
                cnt_clr_c = i_rx_done;
            end
            ST_WAIT_OP: begin
                load_op_c = i_rx_done;
                cnt_en_c  = 1'b1;
                cnt_clr_c = i_rx_done;
            end
            ST_EXEC: begin
                load_res_c = 1'b1;
            end
            ST_WAIT_TX_RES: begin
                load_st_c = i_tx_done;
            end
            default: begin
                load_a_c = 1'b0;
            end
        endcase
    end

    // Status byte and busy flag for the upcoming cycle
    always_comb begin
        invalid_op_c         = !is_valid_op(OP_W'(o_alu_op));
        status_d_c           = '0;
        status_d_c[STAT_OVF] = i_alu_overflow;
        status_d_c[STAT_INV] = invalid_op_c;
        busy_d_c             = (state_d == ST_EXEC) ||
                               (state_d == ST_WAIT_TX_RES) ||
                               (state_d == ST_WAIT_TX_ST);
    end

    // ALU input registers only move on their own load events
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_dataA <= '0;
            o_alu_dataB <= '0;
            o_alu_op    <= '0;
        end else begin
            if (load_a_c)  o_alu_dataA <= i_rx_data;
            if (load_b_c)  o_alu_dataB <= i_rx_data;
            if (load_op_c) o_alu_op    <= i_rx_data[NB_OP-1:0];
        end
    end

    // TX path: result (masked on invalid opcode) first, then the status byte
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            status_q   <= '0;
        end else begin
            o_tx_start <= load_res_c || load_st_c;
            o_busy     <= busy_d_c;
            if (load_res_c) begin
                status_q  <= status_d_c;
                o_tx_data <= invalid_op_c ? '0 : i_alu_result;
            end else if (load_st_c) begin
                o_tx_data <= status_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a behavioural ALU, a UART TX
// responder and a scoreboard of expected TX bytes.
module tb_uart_alu_interface;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic       alu_overflow;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb[$];

    uart_alu_interface #(
        .NB_DATA     (8),
        .NB_OP       (6),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_data      (rx_data),
        .i_rx_done      (rx_done),
        .i_tx_done      (tx_done),
        .i_alu_result   (alu_result),
        .i_alu_overflow (alu_overflow),
        .o_alu_dataA    (alu_a),
        .o_alu_dataB    (alu_b),
        .o_alu_op       (alu_op),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unknown opcodes produce a non-zero sum so masking is visible
    always_comb begin
        alu_result   = alu_a + alu_b;
        alu_overflow = 1'b0;
        case (alu_op)
            6'h20: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            6'h22: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            6'h24: alu_result = alu_a & alu_b;
            6'h25: alu_result = alu_a | alu_b;
            6'h26: alu_result = alu_a ^ alu_b;
            6'h27: alu_result = ~(alu_a | alu_b);
            6'h03: alu_result = 8'($signed(alu_a) >>> alu_b);
            6'h02: alu_result = alu_a >> alu_b;
            default: alu_result = alu_a + alu_b;
        endcase
    end

    // UART TX responder: acknowledge each start a few cycles later
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (3) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Scoreboard: every TX start must match the oldest expected byte
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $error("FAIL tx_unexpected obs=%02h exp=none", tx_data);
                end else begin
                    exp_b = sb.pop_front();
                    assert (tx_data === exp_b) else begin
                        n_fail++;
                        $error("FAIL tx_byte obs=%02h exp=%02h", tx_data, exp_b);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    // Wait, bounded, until both reply bytes are sent and the block is idle
    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy && sb.size() == 0) done = 1'b1;
        end
        check({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic hold_ok;
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a",     32'(alu_a),    32'h0);
        check("rst_b",     32'(alu_b),    32'h0);
        check("rst_op",    32'(alu_op),   32'h0);
        check("rst_txd",   32'(tx_data),  32'h0);
        check("rst_start", 32'(tx_start), 32'h0);
        check("rst_busy",  32'(busy),     32'h0);
        rst_n = 1'b1;

        // ADD with signed overflow and start latency
        rx_byte(8'h7F);
        rx_byte(8'h01);
        sb.push_back(8'h80);
        sb.push_back(8'h01);
        rx_byte(8'h20);
        check("add_exec_busy",  32'(busy),     32'd1);
        check("add_exec_start", 32'(tx_start), 32'd0);
        check("add_op",         32'(alu_op),   32'h20);
        @(posedge clk);
        #1;
        check("add_start_t2",   32'(tx_start), 32'd1);
        wait_idle("add");

        // SUB; ALU inputs must hold through both reply bytes
        rx_byte(8'h05);
        rx_byte(8'h07);
        sb.push_back(8'hFE);
        sb.push_back(8'h00);
        rx_byte(8'h22);
        hold_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (alu_a !== 8'h05 || alu_b !== 8'h07 || alu_op !== 6'h22) hold_ok = 1'b0;
        end
        check("sub_hold", 32'(hold_ok), 32'd1);
        wait_idle("sub");

        // Invalid opcode, plus a byte dropped while waiting on TX
        rx_byte(8'h12);
        rx_byte(8'h34);
        sb.push_back(8'h00);
        sb.push_back(8'h02);
        rx_byte(8'h3F);
        @(posedge clk);
        #1;
        rx_byte(8'h55);
        wait_idle("inv");
        check("inv_idle_busy", 32'(busy),  32'd0);
        check("drop_keep_a",   32'(alu_a), 32'h12);
        check("drop_keep_op",  32'(alu_op), 32'h3F);
        rx_byte(8'h0F);
        rx_byte(8'hF0);
        sb.push_back(8'hFF);
        sb.push_back(8'h00);
        rx_byte(8'h25);
        wait_idle("or");

        // Stall after A: frame resynchronises, no TX during the stall
        rx_byte(8'hAA);
        repeat (20) @(posedge clk);
        #1;
        check("to_busy",   32'(busy),      32'd0);
        check("to_keep_a", 32'(alu_a),     32'hAA);
        check("to_no_tx",  32'(sb.size()), 32'd0);
        rx_byte(8'h01);
        rx_byte(8'h02);
        sb.push_back(8'h00);
        sb.push_back(8'h00);
        rx_byte(8'h24);
        check("to_new_a", 32'(alu_a), 32'h01);
        check("to_new_b", 32'(alu_b), 32'h02);
        wait_idle("and");

        // B arrives on the exact expiry cycle: it must still be accepted
        rx_byte(8'h3C);
        repeat (14) @(posedge clk);
        rx_byte(8'h0F);
        check("edge_b", 32'(alu_b), 32'h0F);
        sb.push_back(8'h33);
        sb.push_back(8'h00);
        rx_byte(8'h26);
        check("edge_a", 32'(alu_a), 32'h3C);
        wait_idle("xor");

        // Reset mid-frame clears everything and produces no TX
        rx_byte(8'h11);
        rx_byte(8'h22);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_a",     32'(alu_a),    32'h0);
        check("mrst_b",     32'(alu_b),    32'h0);
        check("mrst_txd",   32'(tx_data),  32'h0);
        check("mrst_start", 32'(tx_start), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mrst_no_tx", 32'(busy), 32'd0);
        rx_byte(8'h80);
        rx_byte(8'h03);
        sb.push_back(8'h10);
        sb.push_back(8'h00);
        rx_byte(8'h02);
        wait_idle("srl");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
